water_tank_level_model: RTL and testbench

- Synthesizable tank/sensor model that forms the plant end of the water_level_controller interface.
- Takes the controller's motor command plus a drain (consumption) request and integrates a tank level.
- Drives thermometer-coded float sensors S1/S2/S3 back to the controller, closing the loop for simulation and FPGA demos.
- Also reports level, trend state, and sticky overflow/dry-run faults.

---
 rtl/water_tank_level_model.sv | 136 +++++++++++++
 tb/tb_water_tank_level_model.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/water_tank_level_model.sv
// Tank plant model: integrates motor fill / drain ticks into a saturating level, drives S1..S3 float sensors.
// Latency: level and state 1 cycle after the tick cycle, sensors 1 cycle after level. No backpressure.
// Optional macro WATER_SENSOR_HYST_EN gives the sensors set/reset hysteresis of HYST level units.
module water_tank_level_model #(
    parameter int LEVEL_W    = 8,
    parameter int LEVEL_MAX  = 255,
    parameter int INIT_LEVEL = 0,
    parameter int L1_THR     = 64,
    parameter int L2_THR     = 128,
    parameter int L3_THR     = 192,
    parameter int FILL_DIV   = 4,
    parameter int DRAIN_DIV  = 8,
    parameter int HYST       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               motor,
    input  logic               drain_en,
    input  logic               flt_clr,
    output logic               S1,
    output logic               S2,
    output logic               S3,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         state,
    output logic               overflow,
    output logic               dry_run
);

`ifdef WATER_SENSOR_HYST_EN
    localparam int HYST_ON = 1;
`else
    localparam int HYST_ON = 0;
`endif
    // With HYST_EFF = 0 the set/reset sensor collapses to a plain comparison.
    localparam int HYST_EFF = HYST * HYST_ON;

    localparam int FW = (FILL_DIV  > 1) ? $clog2(FILL_DIV)  : 1;
    localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam logic [LEVEL_W-1:0] LMAX  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LZERO = '0;
    localparam logic [LEVEL_W-1:0] LONE  = LEVEL_W'(1);

    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        STEADY  = 3'd1,
        RISING  = 3'd2,
        FALLING = 3'd3,
        FULL    = 3'd4
    } state_t;

    logic [FW-1:0]      fcnt;
    logic [DW-1:0]      dcnt;
    logic               fill_tick;
    logic               drain_tick;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_nxt;
    state_t             state_q;
    state_t             state_nxt;
    logic               ovf_set;
    logic               dry_set;

    assign fill_tick  = motor    && (fcnt == FW'(FILL_DIV - 1));
    assign drain_tick = drain_en && (dcnt == DW'(DRAIN_DIV - 1));
    assign ovf_set    = fill_tick && !drain_tick && (level_q == LMAX);
    assign dry_set    = drain_tick && !fill_tick && (level_q == LZERO);

    function automatic logic sense(input logic cur, input logic [LEVEL_W-1:0] lvl, input int thr);
        if (int'(lvl) >= thr)
            return 1'b1;
        if (int'(lvl) < thr - HYST_EFF)
            return 1'b0;
        return cur;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || !motor || fill_tick)
            fcnt <= '0;
        else
            fcnt <= fcnt + FW'(1);
        if (rst || !drain_en || drain_tick)
            dcnt <= '0;
        else
            dcnt <= dcnt + DW'(1);
    end

    always_comb begin
        level_nxt = level_q;
        if (fill_tick && !drain_tick && level_q != LMAX)
            level_nxt = level_q + LONE;
        else if (drain_tick && !fill_tick && level_q != LZERO)
            level_nxt = level_q - LONE;
    end

    always_comb begin
        state_nxt = STEADY;
        if (level_nxt == LMAX)
            state_nxt = FULL;
        else if (level_nxt == LZERO)
            state_nxt = EMPTY;
        else if (motor && !drain_en)
            state_nxt = RISING;
        else if (drain_en && !motor)
            state_nxt = FALLING;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q  <= LEVEL_W'(INIT_LEVEL);
            state_q  <= EMPTY;
            S1       <= 1'b0;
            S2       <= 1'b0;
            S3       <= 1'b0;
            overflow <= 1'b0;
            dry_run  <= 1'b0;
        end else begin
            level_q <= level_nxt;
            state_q <= state_nxt;
            // Sensors look at the current level, so they trail level by one cycle.
            S1      <= sense(S1, level_q, L1_THR);
            S2      <= sense(S2, level_q, L2_THR);
            S3      <= sense(S3, level_q, L3_THR);
            if (ovf_set)
                overflow <= 1'b1;
            else if (flt_clr)
                overflow <= 1'b0;
            if (dry_set)
                dry_run <= 1'b1;
            else if (flt_clr)
                dry_run <= 1'b0;
        end
    end

    assign level = level_q;
    assign state = state_q;

endmodule

// File: tb/tb_water_tank_level_model.sv
// Directed bench for water_tank_level_model: fill ramp, saturation, drain to dry, simultaneous ticks, mid-fill reset.
module tb_water_tank_level_model;

`ifdef WATER_SENSOR_HYST_EN
    localparam logic HYST_ON = 1'b1;
`else
    localparam logic HYST_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, motor, drain_en, flt_clr;
    logic       s1, s2, s3, ovf, dry;
    logic [7:0] level;
    logic [2:0] state;
    logic       b_s1, b_s2, b_s3, b_ovf, b_dry;
    logic [7:0] b_level;
    logic [2:0] b_state;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    water_tank_level_model u_dut (
        .clk(clk), .rst(rst), .motor(motor), .drain_en(drain_en), .flt_clr(flt_clr),
        .S1(s1), .S2(s2), .S3(s3), .level(level), .state(state),
        .overflow(ovf), .dry_run(dry)
    );

    water_tank_level_model #(.INIT_LEVEL(100), .DRAIN_DIV(4)) u_bal (
        .clk(clk), .rst(rst), .motor(motor), .drain_en(drain_en), .flt_clr(flt_clr),
        .S1(b_s1), .S2(b_s2), .S3(b_s3), .level(b_level), .state(b_state),
        .overflow(b_ovf), .dry_run(b_dry)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; motor = 1'b0; drain_en = 1'b0; flt_clr = 1'b0;
        step(2);
        chk("rst_level", level, 0);
        chk("rst_state", state, 0);
        chk("rst_sens", {s3, s2, s1}, 0);
        chk("rst_faults", {ovf, dry}, 0);

        // Fill ramp
        rst = 1'b0; motor = 1'b1;
        step(3);
        chk("fill_c3_level", level, 0);
        step(1);
        chk("fill_c4_level", level, 1);
        chk("fill_c4_state", state, 2);
        step(252);
        chk("c256_level", level, 64);
        chk("c256_s1", s1, 0);
        step(1);
        chk("c257_s1", s1, 1);
        step(255);
        chk("c512_level", level, 128);
        chk("c512_s2", s2, 0);
        chk("c512_state", state, 2);
        step(1);
        chk("c513_sens", {s3, s2, s1}, 3'b011);
        step(255);
        chk("c768_level", level, 192);
        chk("c768_s3", s3, 0);
        step(1);
        chk("c769_sens", {s3, s2, s1}, 3'b111);

        // Saturation and overflow
        step(251);
        chk("c1020_level", level, 255);
        chk("c1020_state", state, 4);
        chk("c1020_ovf", ovf, 0);
        step(3);
        chk("c1023_ovf", ovf, 0);
        step(1);
        chk("c1024_ovf", ovf, 1);
        chk("c1024_level", level, 255);
        motor = 1'b0; flt_clr = 1'b1;
        step(1);
        chk("ovf_clr", ovf, 0);
        chk("full_idle_state", state, 4);

        // Drain down through the S1 threshold to level 2
        flt_clr = 1'b0; drain_en = 1'b1;
        step(1537);
        chk("d63_level", level, 63);
        chk("d63_s1", s1, HYST_ON);
        step(16);
        chk("d61_level", level, 61);
        chk("d61_s1", s1, HYST_ON);
        step(16);
        chk("d59_level", level, 59);
        chk("d59_s1", s1, 0);
        step(455);
        chk("d2_level", level, 2);
        chk("d2_state", state, 3);

        // Dry run
        step(8);
        chk("d8_level", level, 1);
        step(8);
        chk("d16_level", level, 0);
        chk("d16_state", state, 0);
        chk("d16_dry", dry, 0);
        step(8);
        chk("d24_dry", dry, 1);
        chk("d24_level", level, 0);
        step(7);
        flt_clr = 1'b1;
        step(1);
        chk("dry_set_wins", dry, 1);
        drain_en = 1'b0;
        step(1);
        chk("dry_clr", dry, 0);
        flt_clr = 1'b0;

        // Simultaneous fill and drain at equal rates
        rst = 1'b1;
        step(1);
        chk("bal_rst_level", b_level, 100);
        chk("rst2_state", state, 0);
        rst = 1'b0; motor = 1'b1; drain_en = 1'b1;
        step(40);
        chk("bal_level", b_level, 100);
        chk("bal_state", b_state, 1);
        chk("bal_faults", {b_ovf, b_dry}, 0);

        // Reset in the middle of a fill count
        rst = 1'b1; drain_en = 1'b0;
        step(1);
        rst = 1'b0;
        step(6);
        chk("mid_pre_level", level, 1);
        rst = 1'b1;
        step(1);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_state", state, 0);
        rst = 1'b0;
        step(3);
        chk("mid_c3_level", level, 0);
        step(1);
        chk("mid_c4_level", level, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
